// File: rtl/axifull_pkg.sv
// Shared types and AXI encodings for the axifull burst copy engine.
package axifull_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam logic [2:0] AXSIZE_64  = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Index width of a buffer holding burst_len beats (at least 1 bit).
  function automatic int unsigned len_w(input int unsigned burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

  localparam int unsigned BURST_LEN_DEFAULT = 16;
  localparam int unsigned LEN_W             = len_w(BURST_LEN_DEFAULT);

endpackage

// File: rtl/axifull_copy_master_burst_buf.sv
// Beat buffer between the read and write bursts: registered write port,
// combinational read on an independent address.
module burst_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axifull_copy_master.sv
// AXI4-Full copy engine: one INCR read burst into a local buffer, then one
// INCR write burst of the same beats to the destination address.
module axifull_copy_master
  import axifull_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              axifull_AWVALID,
  input  logic              axifull_AWREADY,
  output logic [ADDR_W-1:0] axifull_AWADDR,
  output logic [7:0]        axifull_AWLEN,
  output logic [2:0]        axifull_AWSIZE,
  output logic [1:0]        axifull_AWBURST,
  output logic              axifull_AWID,
  output logic              axifull_AWLOCK,
  output logic              axifull_AWUSER,
  output logic [3:0]        axifull_AWCACHE,
  output logic [3:0]        axifull_AWQOS,
  output logic [2:0]        axifull_AWPROT,
  output logic              axifull_WVALID,
  input  logic              axifull_WREADY,
  output logic [DATA_W-1:0] axifull_WDATA,
  output logic [7:0]        axifull_WSTRB,
  output logic              axifull_WLAST,
  output logic              axifull_WUSER,
  input  logic              axifull_BVALID,
  output logic              axifull_BREADY,
  input  logic [1:0]        axifull_BRESP,
  input  logic              axifull_BID,
  input  logic              axifull_BUSER,
  output logic              axifull_ARVALID,
  input  logic              axifull_ARREADY,
  output logic [ADDR_W-1:0] axifull_ARADDR,
  output logic [7:0]        axifull_ARLEN,
  output logic [2:0]        axifull_ARSIZE,
  output logic [1:0]        axifull_ARBURST,
  output logic              axifull_ARID,
  output logic              axifull_ARLOCK,
  output logic              axifull_ARUSER,
  output logic [3:0]        axifull_ARCACHE,
  output logic [3:0]        axifull_ARQOS,
  output logic [2:0]        axifull_ARPROT,
  input  logic              axifull_RVALID,
  output logic              axifull_RREADY,
  input  logic [DATA_W-1:0] axifull_RDATA,
  input  logic              axifull_RLAST,
  input  logic [1:0]        axifull_RRESP,
  input  logic              axifull_RID,
  input  logic              axifull_RUSER
);

  localparam int unsigned BUF_AW   = len_w(BURST_LEN);
  localparam logic [7:0]  LAST_CNT = 8'(BURST_LEN - 1);

  state_t            state, state_n;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic              last_beat, r_hs, w_hs;
  logic [DATA_W-1:0] buf_rdata;

  assign last_beat = (cnt == LAST_CNT);
  assign r_hs      = (state == S_R) && axifull_RVALID;
  assign w_hs      = (state == S_W) && axifull_WREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start)           state_n = S_AR;
      S_AR:   if (axifull_ARREADY) state_n = S_R;
      S_R:    if (r_hs && last_beat) state_n = S_AW;
      S_AW:   if (axifull_AWREADY) state_n = S_W;
      S_W:    if (w_hs && last_beat) state_n = S_B;
      S_B:    if (axifull_BVALID)  state_n = S_DONE;
      S_DONE:                      state_n = S_IDLE;
      default:                     state_n = S_IDLE;
    endcase
  end

  // Burst length is taken from cnt alone; RLAST only feeds the error flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt   <= '0;
      src_q <= '0;
      dst_q <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          cnt   <= '0;
          error <= 1'b0;
        end
        S_R: if (r_hs) begin
          cnt <= last_beat ? '0 : cnt + 8'd1;
          if (axifull_RRESP != RESP_OKAY || axifull_RLAST != last_beat) error <= 1'b1;
        end
        S_W: if (w_hs) cnt <= last_beat ? '0 : cnt + 8'd1;
        S_B: if (axifull_BVALID && axifull_BRESP != RESP_OKAY) error <= 1'b1;
        default: ;
      endcase
    end
  end

  burst_buf #(.DEPTH(BURST_LEN), .AW(BUF_AW), .DW(DATA_W)) u_buf (
    .clk   (ACLK),
    .we    (r_hs),
    .waddr (cnt[BUF_AW-1:0]),
    .wdata (axifull_RDATA),
    .raddr (cnt[BUF_AW-1:0]),
    .rdata (buf_rdata)
  );

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  assign axifull_ARVALID = (state == S_AR);
  assign axifull_ARADDR  = src_q;
  assign axifull_ARLEN   = LAST_CNT;
  assign axifull_ARSIZE  = AXSIZE_64;
  assign axifull_ARBURST = BURST_INCR;
  assign axifull_ARID    = 1'b0;
  assign axifull_ARLOCK  = 1'b0;
  assign axifull_ARUSER  = 1'b0;
  assign axifull_ARCACHE = '0;
  assign axifull_ARQOS   = '0;
  assign axifull_ARPROT  = '0;
  assign axifull_RREADY  = (state == S_R);

  assign axifull_AWVALID = (state == S_AW);
  assign axifull_AWADDR  = dst_q;
  assign axifull_AWLEN   = LAST_CNT;
  assign axifull_AWSIZE  = AXSIZE_64;
  assign axifull_AWBURST = BURST_INCR;
  assign axifull_AWID    = 1'b0;
  assign axifull_AWLOCK  = 1'b0;
  assign axifull_AWUSER  = 1'b0;
  assign axifull_AWCACHE = '0;
  assign axifull_AWQOS   = '0;
  assign axifull_AWPROT  = '0;

  assign axifull_WVALID  = (state == S_W);
  assign axifull_WDATA   = buf_rdata;
  assign axifull_WSTRB   = '1;
  assign axifull_WLAST   = (state == S_W) && last_beat;
  assign axifull_WUSER   = 1'b0;
  assign axifull_BREADY  = (state == S_B);

  logic unused_sink;
  assign unused_sink = ^{axifull_BID, axifull_BUSER, axifull_RID, axifull_RUSER, cnt};

endmodule

// File: tb/tb_axifull_copy_master.sv
// Directed bench for axifull_copy_master; the initial block plays the memory slave.
module tb_axifull_copy_master;

  localparam int BL = 16;

  logic        ACLK, ARESETn, start, busy, done, error;
  logic [31:0] src_addr, dst_addr;
  logic        AWVALID, AWREADY, AWID, AWLOCK, AWUSER;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE, AWQOS;
  logic        WVALID, WREADY, WLAST, WUSER;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        BVALID, BREADY, BID, BUSER;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY, ARID, ARLOCK, ARUSER;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE, ARQOS;
  logic        RVALID, RREADY, RLAST, RID, RUSER;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;

  logic [63:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  axifull_copy_master #(.DATA_W(64), .ADDR_W(32), .BURST_LEN(BL)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .error(error),
    .axifull_AWVALID(AWVALID), .axifull_AWREADY(AWREADY), .axifull_AWADDR(AWADDR),
    .axifull_AWLEN(AWLEN), .axifull_AWSIZE(AWSIZE), .axifull_AWBURST(AWBURST),
    .axifull_AWID(AWID), .axifull_AWLOCK(AWLOCK), .axifull_AWUSER(AWUSER),
    .axifull_AWCACHE(AWCACHE), .axifull_AWQOS(AWQOS), .axifull_AWPROT(AWPROT),
    .axifull_WVALID(WVALID), .axifull_WREADY(WREADY), .axifull_WDATA(WDATA),
    .axifull_WSTRB(WSTRB), .axifull_WLAST(WLAST), .axifull_WUSER(WUSER),
    .axifull_BVALID(BVALID), .axifull_BREADY(BREADY), .axifull_BRESP(BRESP),
    .axifull_BID(BID), .axifull_BUSER(BUSER),
    .axifull_ARVALID(ARVALID), .axifull_ARREADY(ARREADY), .axifull_ARADDR(ARADDR),
    .axifull_ARLEN(ARLEN), .axifull_ARSIZE(ARSIZE), .axifull_ARBURST(ARBURST),
    .axifull_ARID(ARID), .axifull_ARLOCK(ARLOCK), .axifull_ARUSER(ARUSER),
    .axifull_ARCACHE(ARCACHE), .axifull_ARQOS(ARQOS), .axifull_ARPROT(ARPROT),
    .axifull_RVALID(RVALID), .axifull_RREADY(RREADY), .axifull_RDATA(RDATA),
    .axifull_RLAST(RLAST), .axifull_RRESP(RRESP), .axifull_RID(RID), .axifull_RUSER(RUSER)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dly(input int mode, input int k);
    if (mode == 0) return 0;
    return (k * 7 + mode * 3) % 6;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, done, error, WLAST}, 0);
    check({tag, "_araddr"}, ARADDR, 0);
    check({tag, "_awaddr"}, AWADDR, 0);
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int mode,
                         input int rlast_beat, input logic [1:0] bresp, input int start_w_beat,
                         input int reset_w_beat, input logic exp_err);
    int n;
    logic [63:0] wd;
    @(negedge ACLK);
    src_addr = src; dst_addr = dst; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; src_addr = '0; dst_addr = '0;
    check("busy_after_start", busy, 1);
    check("arvalid_rise", ARVALID, 1);
    check("error_cleared", error, 0);
    check("rready_in_ar", RREADY, 0);
    check("araddr", ARADDR, src);
    check("ar_fields", {ARLEN, ARSIZE, ARBURST}, {8'd15, 3'b011, 2'b01});
    check("ar_zero_fields", {ARID, ARLOCK, ARUSER, ARCACHE, ARQOS, ARPROT}, 0);
    for (int k = 0; k < dly(mode, 0); k++) begin
      @(negedge ACLK);
      check("ar_stall", {ARVALID, ARADDR}, {1'b1, src});
    end
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    for (int i = 0; i < BL; i++) begin
      repeat (dly(mode, i + 1)) @(negedge ACLK);
      RVALID = 1'b1; RDATA = mem[src + 32'(i)]; RLAST = (i == rlast_beat); RRESP = 2'b00;
      check("rready", RREADY, 1);
      @(negedge ACLK);
      RVALID = 1'b0; RLAST = 1'b0;
    end
    n = 0;
    while (!AWVALID && n < 20) begin @(negedge ACLK); n++; end
    check("awvalid_after_r", {AWVALID, RREADY, ARVALID}, 3'b100);
    check("awaddr", AWADDR, dst);
    check("aw_fields", {AWLEN, AWSIZE, AWBURST}, {8'd15, 3'b011, 2'b01});
    check("aw_zero_fields", {AWID, AWLOCK, AWUSER, AWCACHE, AWQOS, AWPROT, WUSER}, 0);
    for (int k = 0; k < dly(mode, 3); k++) begin
      @(negedge ACLK);
      check("aw_stall", {AWVALID, AWADDR}, {1'b1, dst});
    end
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    for (int i = 0; i < BL; i++) begin
      if (i == reset_w_beat) begin
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        check_all_zero("reset_mid_w");
        return;
      end
      check("wvalid", WVALID, 1);
      for (int k = 0; k < dly(mode, i + 2); k++) begin
        @(negedge ACLK);
        check("w_stall", {WVALID, WDATA}, {1'b1, mem[src + 32'(i)]});
      end
      check("wdata", WDATA, mem[src + 32'(i)]);
      check("wlast_wstrb", {WLAST, WSTRB}, {(i == BL - 1) ? 1'b1 : 1'b0, 8'hFF});
      wd = WDATA;
      if (i == start_w_beat) start = 1'b1;
      WREADY = 1'b1;
      @(negedge ACLK);
      WREADY = 1'b0; start = 1'b0;
      mem[dst + 32'(i)] = wd;
    end
    check("b_phase", {BREADY, WVALID, AWVALID}, 3'b100);
    repeat (dly(mode, 5)) @(negedge ACLK);
    BVALID = 1'b1; BRESP = bresp;
    @(negedge ACLK);
    BVALID = 1'b0; BRESP = 2'b00;
    check("done_pulse", {done, busy, error}, {1'b1, 1'b0, exp_err});
    @(negedge ACLK);
    check("after_done", {done, busy, ARVALID, error}, {3'b000, exp_err});
    repeat (3) @(negedge ACLK);
    check("no_second_job", {ARVALID, busy}, 2'b00);
  endtask

  task automatic check_copy(input logic [31:0] dst, input logic [31:0] src);
    for (int i = 0; i < BL; i++) begin
      // Source words: 0..63 hold their index, 64.. hold C0DEF00D:index.
      check("mem_copy", mem[dst + 32'(i)],
            (src < 64) ? 64'(src + 32'(i)) : {32'hC0DE_F00D, src + 32'(i)});
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = (k < 64) ? 64'(k) : {32'hC0DE_F00D, 32'(k)};
    ARESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0; BID = 1'b0; BUSER = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = '0; RID = 1'b0; RUSER = 1'b0;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESETn = 1'b1;

    run_job(32'd0,  32'd32,  0, 15, 2'b00, -1, -1, 1'b0);
    check_copy(32'd32, 32'd0);
    run_job(32'd64, 32'd96,  1, 15, 2'b00, -1, -1, 1'b0);
    check_copy(32'd96, 32'd64);
    run_job(32'd0,  32'd48,  2, 15, 2'b00,  3, -1, 1'b0);
    check_copy(32'd48, 32'd0);
    run_job(32'd64, 32'd112, 0, 15, 2'b10, -1, -1, 1'b1);
    run_job(32'd0,  32'd128, 0,  9, 2'b00, -1, -1, 1'b1);
    check_copy(32'd128, 32'd0);
    run_job(32'd64, 32'd160, 0, 15, 2'b00, -1,  5, 1'b0);
    run_job(32'd0,  32'd176, 1, 15, 2'b00, -1, -1, 1'b0);
    check_copy(32'd176, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
